// File: rtl/adsr_pkg.sv
// Shared types and helpers for the multi-voice ADSR envelope and its gain stage.
package adsr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_t;

  // Wide enough for any level/gain width this block is realistically built with.
  localparam int CALC_W = 34;

  function automatic logic [CALC_W-1:0] full_scale(input int gain_width);
    return CALC_W'(1) << gain_width;
  endfunction

  function automatic logic [CALC_W-1:0] clamp_sustain(input logic [CALC_W-1:0] sustain,
                                                      input logic [CALC_W-1:0] full);
    return (sustain > full) ? full : sustain;
  endfunction

endpackage

// File: rtl/adsr_envelope_mv_gain_mul.sv
// Registered signed sample x unsigned gain multiply with fractional shift and tag pass-through.
module adsr_gain_mul
  import adsr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int GAIN_WIDTH = 16,
  parameter int TAG_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [TAG_W-1:0]             in_tag,
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic [GAIN_WIDTH:0]          gain,
  output logic                         out_valid,
  output logic [TAG_W-1:0]             out_tag,
  output logic signed [DATA_WIDTH-1:0] data_out
);

  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 2;

  logic signed [PW-1:0] prod;
  logic                 unused_bits;

  // Gain gets a zero sign bit so the product stays a true signed x unsigned multiply.
  assign prod = PW'(sample) * PW'($signed({1'b0, gain}));

  // Taking the bit slice above the fraction is the arithmetic shift, rounding toward -inf.
  assign unused_bits = ^{prod[GAIN_WIDTH-1:0], prod[PW-1:GAIN_WIDTH+DATA_WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      data_out  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_tag  <= in_tag;
        data_out <= prod[GAIN_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/adsr_envelope_mv.sv
// Multi-voice linear ADSR envelope on a voice-tagged sample stream; one voice updated per strobe.
//
// state   | meaning
// IDLE    | silent, level held at 0
// ATTACK  | level rising by attack_step per sample toward full scale
// DECAY   | level falling by decay_step per sample toward sustain
// SUSTAIN | level follows the (clamped) sustain input live
// RELEASE | level falling by release_step per sample toward 0
module adsr_envelope_mv
  import adsr_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int GAIN_WIDTH = 16,
  parameter  int NUM_VOICES = 8,
  localparam int VOICE_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [VOICE_W-1:0]           in_voice,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic [NUM_VOICES-1:0]        play,
  input  logic [GAIN_WIDTH:0]          attack_step,
  input  logic [GAIN_WIDTH:0]          decay_step,
  input  logic [GAIN_WIDTH:0]          sustain_level,
  input  logic [GAIN_WIDTH:0]          release_step,
  output logic                         out_valid,
  output logic [VOICE_W-1:0]           out_voice,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic [NUM_VOICES-1:0]        active
);

  localparam int            LW   = GAIN_WIDTH + 2;
  localparam logic [LW-1:0] FULL = LW'(full_scale(GAIN_WIDTH));

  adsr_state_t         state_q [NUM_VOICES];
  logic [GAIN_WIDTH:0] level_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_q;

  adsr_state_t cur_state, eff_state, nxt_state;
  logic [LW-1:0] cur_lvl, nxt_lvl, sus, a_step, d_step, r_step;
  logic          gate;
  logic          unused_lvl_msb;

  logic                         s1_valid;
  logic [VOICE_W-1:0]           s1_voice;
  logic signed [DATA_WIDTH-1:0] s1_data;
  logic [GAIN_WIDTH:0]          s1_level;

  always_comb begin
    cur_state = state_q[in_voice];
    cur_lvl   = {1'b0, level_q[in_voice]};
    gate      = play[in_voice];
    sus       = LW'(clamp_sustain(CALC_W'(sustain_level), CALC_W'(FULL)));
    a_step    = {1'b0, attack_step};
    d_step    = {1'b0, decay_step};
    r_step    = {1'b0, release_step};

    eff_state = cur_state;
    if (!gate && cur_state != IDLE)
      eff_state = RELEASE;
    else if (gate && (cur_state == IDLE || cur_state == RELEASE))
      eff_state = ATTACK;

    nxt_state = eff_state;
    nxt_lvl   = cur_lvl;
    unique case (eff_state)
      ATTACK: begin
        if (cur_lvl + a_step >= FULL || a_step == '0) begin
          nxt_lvl   = FULL;
          nxt_state = DECAY;
        end else begin
          nxt_lvl = cur_lvl + a_step;
        end
      end
      DECAY: begin
        if (cur_lvl <= sus + d_step || d_step == '0) begin
          nxt_lvl   = sus;
          nxt_state = SUSTAIN;
        end else begin
          nxt_lvl = cur_lvl - d_step;
        end
      end
      SUSTAIN: nxt_lvl = sus;
      RELEASE: begin
        if (cur_lvl <= r_step || r_step == '0) begin
          nxt_lvl   = '0;
          nxt_state = IDLE;
        end else begin
          nxt_lvl = cur_lvl - r_step;
        end
      end
      IDLE: nxt_lvl = '0;
      default: begin
        nxt_lvl   = '0;
        nxt_state = IDLE;
      end
    endcase
  end

  // Level never exceeds FULL, so the top bit of the wide arithmetic is always 0.
  assign unused_lvl_msb = nxt_lvl[LW-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v] <= IDLE;
        level_q[v] <= '0;
      end
      active_q <= '0;
    end else if (in_valid) begin
      state_q[in_voice]  <= nxt_state;
      level_q[in_voice]  <= nxt_lvl[GAIN_WIDTH:0];
      active_q[in_voice] <= (nxt_state != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_voice <= '0;
      s1_data  <= '0;
      s1_level <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_voice <= in_voice;
        s1_data  <= data_in;
        s1_level <= nxt_lvl[GAIN_WIDTH:0];
      end
    end
  end

  adsr_gain_mul #(
    .DATA_WIDTH (DATA_WIDTH),
    .GAIN_WIDTH (GAIN_WIDTH),
    .TAG_W      (VOICE_W)
  ) u_gain (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_tag    (s1_voice),
    .sample    (s1_data),
    .gain      (s1_level),
    .out_valid (out_valid),
    .out_tag   (out_voice),
    .data_out  (data_out)
  );

  assign active = active_q;

endmodule

// File: tb/tb_adsr_envelope_mv.sv
// Directed bench for adsr_envelope_mv with hand-computed envelope outputs.
module tb_adsr_envelope_mv;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [2:0]         in_voice;
  logic signed [31:0] data_in;
  logic [7:0]         play;
  logic [16:0]        attack_step, decay_step, sustain_level, release_step;
  logic               out_valid;
  logic [2:0]         out_voice;
  logic signed [31:0] data_out;
  logic [7:0]         active;

  int vectors     = 0;
  int miscompares = 0;

  adsr_envelope_mv dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_voice      (in_voice),
    .data_in       (data_in),
    .play          (play),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .out_valid     (out_valid),
    .out_voice     (out_voice),
    .data_out      (data_out),
    .active        (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sample, then watch the 2-cycle latency, the output, and the hold afterwards.
  task automatic sample(input int v, input int d, input int exp, input logic [7:0] exp_act);
    in_valid = 1'b1;
    in_voice = 3'(v);
    data_in  = d;
    tick();
    in_valid = 1'b0;
    chk("active", active, exp_act);
    chk("gap_valid", out_valid, 0);
    tick();
    chk("out_valid", out_valid, 1);
    chk("out_voice", out_voice, v);
    chk("data_out", data_out, exp);
    tick();
    chk("hold_valid", out_valid, 0);
    chk("hold_data", data_out, exp);
    tick();
  endtask

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_voice      = '0;
    data_in       = '0;
    play          = '0;
    attack_step   = 17'd16384;
    decay_step    = 17'd8192;
    sustain_level = 17'd49152;
    release_step  = 17'd16384;
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_voice", out_voice, 0);
    chk("rst_data", data_out, 0);
    chk("rst_active", active, 0);
    rst = 1'b0;

    // attack / decay / sustain
    play = 8'h01;
    sample(0, 1000, 250, 8'h01);
    sample(0, 1000, 500, 8'h01);
    sample(0, 1000, 750, 8'h01);
    sample(0, 1000, 1000, 8'h01);
    sample(0, 1000, 875, 8'h01);
    sample(0, 1000, 750, 8'h01);
    sample(0, 1000, 750, 8'h01);

    // release
    play = 8'h00;
    sample(0, 1000, 500, 8'h01);
    sample(0, 1000, 250, 8'h01);
    sample(0, 1000, 0, 8'h00);

    // zero attack/decay steps, negative samples, release
    attack_step = 17'd0;
    decay_step  = 17'd0;
    play = 8'h01;
    sample(0, -1000, -1000, 8'h01);
    sample(0, -1000, -750, 8'h01);
    play = 8'h00;
    sample(0, -1000, -500, 8'h01);
    sample(0, -1000, -250, 8'h01);
    sample(0, -1000, 0, 8'h00);

    // retrigger during release keeps the current level
    play = 8'h01;
    sample(0, 1000, 1000, 8'h01);
    sample(0, 1000, 750, 8'h01);
    play = 8'h00;
    sample(0, 1000, 500, 8'h01);
    attack_step = 17'd16384;
    play = 8'h01;
    sample(0, 1000, 750, 8'h01);
    sample(0, 1000, 1000, 8'h01);

    // zero release step drops straight to idle
    release_step = 17'd0;
    play = 8'h00;
    sample(0, 1000, 0, 8'h00);

    // sustain clamp and live sustain tracking
    sustain_level = 17'd70000;
    attack_step   = 17'd0;
    decay_step    = 17'd8192;
    play = 8'h01;
    sample(0, 1000, 1000, 8'h01);
    sample(0, 1000, 1000, 8'h01);
    sample(0, 1000, 1000, 8'h01);
    sustain_level = 17'd49152;
    sample(0, 1000, 750, 8'h01);
    play = 8'h00;
    sample(0, 1000, 0, 8'h00);

    // round-robin interleave, only voice 3 gated
    attack_step  = 17'd16384;
    release_step = 17'd16384;
    play = 8'h08;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) begin
        in_valid = 1'b1;
        in_voice = 3'(i % 8);
        data_in  = 100 * ((i % 8) + 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk("rr_valid", out_valid, 1);
        chk("rr_voice", out_voice, (i - 1) % 8);
        chk("rr_data", data_out, (((i - 1) % 8) == 3) ? 100 * (((i - 1) / 8) + 1) : 0);
      end
    end
    tick();
    chk("rr_idle_valid", out_valid, 0);
    chk("rr_active", active, 8'h08);

    // voice 2 to sustain, then reset mid-note
    attack_step = 17'd0;
    decay_step  = 17'd0;
    play = 8'h04;
    sample(2, 1000, 1000, 8'h0C);
    sample(2, 1000, 750, 8'h0C);
    sample(2, 1000, 750, 8'h0C);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_active", active, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", data_out, 0);
    play = 8'h00;
    sample(2, 1000, 0, 8'h00);
    // voice 3 was at half scale before reset; its level must restart from 0
    attack_step = 17'd16384;
    play = 8'h08;
    sample(3, 1000, 250, 8'h08);

    // back-to-back samples for one voice see each other's update
    play     = 8'h09;
    in_valid = 1'b1;
    in_voice = 3'd0;
    data_in  = 1000;
    tick();
    tick();
    in_valid = 1'b0;
    chk("b2b_first", data_out, 250);
    chk("b2b_first_voice", out_voice, 0);
    tick();
    chk("b2b_second", data_out, 500);
    chk("b2b_second_valid", out_valid, 1);
    chk("b2b_active", active, 8'h09);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adsr_envelope_mv.md
Name: adsr_envelope_mv

Overview:
- Multi-voice ADSR envelope generator: the successor to the single-voice attack/release gate envelope.
- Applies a per-voice linear gain (attack, decay, sustain, release) to a time-multiplexed sample stream tagged with a voice index.
- Sits between the oscillator bank and the voice mixer.
- Exports per-voice activity flags for the voice allocator.

Parameters:
- DATA_WIDTH, 32, signed sample width.
- GAIN_WIDTH, 16, fractional bits of gain; full scale FULL = 2**GAIN_WIDTH; level register is GAIN_WIDTH+1 bits unsigned.
- NUM_VOICES, 8, number of voices; VOICE_W = max(1, $clog2(NUM_VOICES)).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample strobe.
- in_voice  in  VOICE_W  voice index of data_in.
- data_in  in  DATA_WIDTH signed  raw voice sample.
- play  in  NUM_VOICES  per-voice gate.
- attack_step  in  GAIN_WIDTH+1  level increment per sample in ATTACK.
- decay_step  in  GAIN_WIDTH+1  level decrement per sample in DECAY.
- sustain_level  in  GAIN_WIDTH+1  sustain gain, clamped to FULL.
- release_step  in  GAIN_WIDTH+1  level decrement per sample in RELEASE.
- out_valid  out  1  output strobe.
- out_voice  out  VOICE_W  voice index of data_out.
- data_out  out  DATA_WIDTH signed  enveloped sample.
- active  out  NUM_VOICES  1 when voice state != IDLE.

Behaviour:
- Reset: all voices IDLE, level 0; out_valid, out_voice, data_out, active all 0. A reset mid-note drops the note immediately; no release tail.
- Voice v is updated only on a cycle with in_valid=1 and in_voice=v. Its play bit is sampled on that cycle only. Voices not addressed hold state.
- Stage 1 is a read-modify-write of the state/level arrays in a single cycle. Back-to-back samples for the same voice therefore see the prior update, with no hazard or bubble.
- Effective state E:
  - play=0 and state != IDLE -> RELEASE.
  - play=1 and state in {IDLE, RELEASE} -> ATTACK. Retrigger continues from the current level; level is not zeroed.
  - Otherwise E = current state.
- Step applied in E:
  - ATTACK: if level+attack_step >= FULL or attack_step == 0, level=FULL and state=DECAY; else level += attack_step.
  - DECAY: if level <= sustain+decay_step or decay_step == 0, level=sustain and state=SUSTAIN; else level -= decay_step.
  - SUSTAIN: level = sustain; sustain_level changes are tracked live.
  - RELEASE: if level <= release_step or release_step == 0, level=0 and state=IDLE; else level -= release_step.
  - IDLE: level = 0.
- Arithmetic:
  - All level arithmetic is GAIN_WIDTH+2 bits; no wrap-around.
  - The sustain value used everywhere is min(sustain_level, FULL).
- Output:
  - data_out = (data_in * new_level) >>> GAIN_WIDTH, signed product of DATA_WIDTH+GAIN_WIDTH+2 bits, truncated toward -inf.
  - At level FULL, data_out == data_in exactly; at level 0, data_out == 0.
- Latency: out_valid, out_voice and data_out appear exactly 2 cycles after the corresponding in_valid. out_valid is 0 otherwise, and data_out holds its last value when out_valid=0.
- active[v] is registered and reflects the voice's state after its most recent update.
- Step inputs are global and may change at any cycle; the value present on a voice's update cycle is the one used.

Decomposition:
- Package adsr_pkg:
  - enum adsr_state_t {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE}.
  - function full_scale(GAIN_WIDTH).
  - function clamp_sustain.
- One sub-module, adsr_gain_mul: a registered signed sample x unsigned gain multiply with shift and tag pass-through. It forms stage 2 and is reusable by the mixer's volume control.
- The state/level arrays and step logic stay in the top module.

Test Plan:
- Attack/decay/sustain, defaults (FULL=65536): attack_step=16384, decay_step=8192, sustain=49152, voice 0, data_in=1000, play[0]=1, one sample per 4 cycles -> data_out 250, 500, 750, 1000, 875, 750, 750...; active[0]=1 from the first output.
- Release: from sustain 49152, release_step=16384, drop play[0] -> data_out 500, 250, 0; active[0] falls after the third sample. data_in=-1000 gives -500, -250, 0.
- Retrigger: play[0] low for 1 sample during release (level 32768), then high with attack_step=16384 -> next level 49152 (data_out 750 for 1000 in), not 16384.
- Multi-voice interleave: voices 0..7 round-robin every cycle, only play[3]=1 -> only out_voice=3 non-zero; active=8'b0000_1000; out_voice sequence matches in_voice delayed 2 cycles.
- Zero-step edges: attack_step=0 -> first sample is full scale (data_out==data_in). release_step=0 -> next sample 0 and IDLE. sustain_level=70000 clamps to FULL.
- Reset mid-note: assert rst during SUSTAIN of voice 2 -> next cycle active=0, out_valid=0, data_out=0; the next sample for voice 2 with play=0 outputs 0.
